// File: rtl/bcd_conv_pkg.sv
// bcd_conv_pkg: shared state encoding and default sizes for the BCD-to-binary converter
package bcd_conv_pkg;
  localparam int DIGITS_DEF = 4;
  localparam int BW_DEF = 14;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/bcd_conv_ctrl_mac10.sv
// bcd_mac10: combinational acc*10 + digit, truncated to BW bits
import bcd_conv_pkg::*;
module bcd_mac10 #(
  parameter int BW = BW_DEF
) (
  input  logic [BW-1:0] acc,
  input  logic [3:0]    digit,
  output logic [BW-1:0] res
);
  assign res = (acc << 3) + (acc << 1) + BW'(digit);
endmodule

// File: rtl/bcd_conv_ctrl.sv
// bcd_conv_ctrl: serial packed-BCD to binary converter, one digit per cycle, MSD first; BCD_CONV_CHECK_EN adds illegal-digit flagging
import bcd_conv_pkg::*;
module bcd_conv_ctrl #(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BW = BW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BW-1:0]       bin_out,
  output logic                err
);
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);
  state_t state;
  logic [4*DIGITS-1:0] op;
  logic [CW-1:0] cnt;
  logic [BW-1:0] acc;
  logic [BW-1:0] nxt;
  logic [3:0] dig;
  // operand shifts left each CONV cycle so the current digit is always the top nibble
  assign dig = op[4*DIGITS-1 -: 4];
  bcd_mac10 #(.BW(BW)) u_mac (
    .acc(acc),
    .digit(dig),
    .res(nxt)
  );
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign bin_out = acc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op <= '0;
      cnt <= '0;
      acc <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op <= bcd_in;
          cnt <= '0;
          acc <= '0;
          state <= CONV;
        end
        CONV: begin
          acc <= nxt;
          op <= op << 4;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef BCD_CONV_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if (state == IDLE && in_valid) err_q <= 1'b0;
    else if (state == CONV && dig > 4'd9) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_conv_ctrl.sv
// tb_bcd_conv_ctrl: table-driven and randomized checks of bcd_conv_ctrl against a decimal-weight model
module tb_bcd_conv_ctrl;
  localparam int DIGITS = 4;
  localparam int BW = 14;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [4*DIGITS-1:0] bcd_in = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [BW-1:0] bin_out;
  logic err;
  int checks = 0;
  int errors = 0;
  bcd_conv_ctrl #(.DIGITS(DIGITS), .BW(BW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .bcd_in(bcd_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .bin_out(bin_out),
    .err(err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] bcd;
    int stall;
    int glitch;
    logic [13:0] exp_bin;
    logic exp_err;
  } vec_t;
  vec_t tbl[6];
`ifdef BCD_CONV_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif
  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, got, exp);
    end
  endtask
  function automatic logic [13:0] ref_bin(input logic [15:0] b);
    int v = 0;
    for (int i = 0; i < DIGITS; i++) v += int'(b[4*i +: 4]) * (10 ** i);
    return 14'(v % (1 << BW));
  endfunction
  function automatic logic ref_err(input logic [15:0] b);
    logic e = 1'b0;
    for (int i = 0; i < DIGITS; i++) e |= b[4*i +: 4] > 4'd9;
    return e & CHK;
  endfunction
  task automatic run(input string nm, input logic [15:0] b, input int stall, input int glitch,
                     input logic [13:0] eb, input logic ee);
    int n;
    @(negedge clk);
    chk({nm, " in_ready idle"}, int'(in_ready), 1);
    in_valid = 1'b1;
    bcd_in = b;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    bcd_in = 16'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      if (glitch != 0 && n == 1) begin
        chk({nm, " in_ready conv"}, int'(in_ready), 0);
        in_valid = 1'b1;
        bcd_in = 16'h1111;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n++;
    end
    chk({nm, " latency"}, n, DIGITS);
    chk({nm, " bin_out"}, int'(bin_out), int'(eb));
    chk({nm, " err"}, int'(err), int'(ee));
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk({nm, " stall out_valid"}, int'(out_valid), 1);
      chk({nm, " stall bin_out"}, int'(bin_out), int'(eb));
      chk({nm, " stall in_ready"}, int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, " release out_valid"}, int'(out_valid), 0);
    chk({nm, " release in_ready"}, int'(in_ready), 1);
  endtask
  initial begin
    logic [15:0] r;
    tbl[0] = '{16'h9999, 0, 0, 14'd9999, 1'b0};
    tbl[1] = '{16'h0000, 0, 0, 14'd0, 1'b0};
    tbl[2] = '{16'h0407, 1, 0, 14'd407, 1'b0};
    tbl[3] = '{16'h1234, 3, 1, 14'd1234, 1'b0};
    tbl[4] = '{16'h0042, 0, 0, 14'd42, 1'b0};
    tbl[5] = '{16'h12A4, 2, 0, 14'd1304, CHK};
    #12;
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset bin_out", int'(bin_out), 0);
    chk("reset err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post reset in_ready", int'(in_ready), 1);
    for (int i = 0; i < 6; i++)
      run($sformatf("tbl%0d", i), tbl[i].bcd, tbl[i].stall, tbl[i].glitch, tbl[i].exp_bin, tbl[i].exp_err);
    @(negedge clk);
    in_valid = 1'b1;
    bcd_in = 16'h9999;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midconv rst out_valid", int'(out_valid), 0);
    chk("midconv rst bin_out", int'(bin_out), 0);
    chk("midconv rst err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk("no result after reset", int'(out_valid), 0);
    end
    run("after reset", 16'h0042, 0, 0, 14'd42, 1'b0);
    for (int k = 0; k < 30; k++) begin
      r = 16'($urandom);
      if ($urandom_range(0, 3) != 0)
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
      run($sformatf("rnd%0d", k), r, int'($urandom_range(0, 2)), 0, ref_bin(r), ref_err(r));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
